vigna_bus_arbiter: RTL and testbench
====================================

# vigna_bus_arbiter

Two-master to one-slave bus arbiter that lets the vigna core's instruction port and data port share a single memory port. It sits between the core and a unified memory/peripheral interconnect, serialising fetches and loads/stores with the same valid/ready handshake on all sides. It also aborts hung transactions after a configurable timeout.

## Interface
- `ARB_MODE`, default 0: 0 = fixed priority, data port wins; 1 = round-robin on simultaneous requests.
- `TIMEOUT`, default 0: number of `m_valid` cycles without `m_ready` before an abort; 0 disables the timeout.
- `CNT_W`, default 16: width of the timeout counter; requires `TIMEOUT < 2**CNT_W`.

Ports:
- `clk  in  1`: the single clock.
- `resetn  in  1`: asynchronous, active-low reset.
- `i_valid  in  1`: instruction read request.
- `i_ready  out  1`: instruction transfer complete.
- `i_addr  in  32`: fetch address.
- `i_rdata  out  32`: fetched word, valid while `i_ready`.
- `d_valid  in  1`: data request.
- `d_ready  out  1`: data transfer complete.
- `d_addr  in  32`: data address.
- `d_rdata  out  32`: load data, valid while `d_ready`.
- `d_wdata  in  32`: store data.
- `d_wstrb  in  4`: byte strobes; 0 = read.
- `m_valid  out  1`: memory request.
- `m_ready  in  1`: memory completion.
- `m_addr  out  32`: memory address.
- `m_rdata  in  32`: memory read data.
- `m_wdata  out  32`: memory write data.
- `m_wstrb  out  4`: memory byte strobes.
- `timeout_err  out  1`: high during an abort cycle.
- `bus_owner  out  2`: 00 idle, 01 instruction, 10 data.

## Operation
- **States**: IDLE, GRANT_I, GRANT_D; encoding is reflected on `bus_owner`.
- **IDLE**:
  - Sample `i_valid` and `d_valid`.
  - If only one is high, grant that port.
  - If both are high and `ARB_MODE`=0, grant D.
  - If both are high and `ARB_MODE`=1, grant the port not granted last. `last_grant` resets to I, so D wins the first contention.
  - On grant, register `m_addr`, `m_wdata` and `m_wstrb` from the winner. Instruction grants force `m_wdata`=0 and `m_wstrb`=0.
  - Set `m_valid`=1, clear the timeout counter, and update `last_grant`.
- **GRANT_x**:
  - `m_*` request outputs are held stable.
  - The granted port's ready is `m_ready | abort`, combinational.
  - The granted port's rdata is `m_rdata`, or 0 on abort.
  - The non-granted ready is always 0. Both rdata outputs show `m_rdata` when not aborting.
  - On the completion edge (ready high): `m_valid`←0, `m_wstrb`←0, `m_wdata`←0, state←IDLE.
- **Abort**: `abort` = granted & `TIMEOUT`≠0 & !`m_ready` & `cnt`==`TIMEOUT`-1.
  - The counter increments on each granted cycle where `m_ready` is low.
  - `timeout_err` = `abort`.
  - If `m_ready` and the timeout coincide, this is normal completion: rdata comes from memory and no error is flagged.
- **Requester rule**: a requester holds valid and its payload until its ready is seen, and drops or re-issues valid at that edge. The arbiter never reads requester payload outside IDLE.
- **Reset**: while `resetn`=0, including mid-transaction, all outputs are 0 immediately: `m_valid`, `m_addr`, `m_wdata`, `m_wstrb`, `bus_owner`, and both readies. State←IDLE, `cnt`←0, `last_grant`←I. The memory side must tolerate a dropped request.

## Timing
- **Grant latency**: valid sampled high at edge N in IDLE → `m_valid` high in cycle N+1.
- **Completion**: `m_ready` in cycle M → requester ready in cycle M (zero added latency) → `m_valid` low in cycle M+1.
- **Bubble**: a request pending at M+1 is granted at edge M+1, giving `m_valid` in M+2. There is a minimum one idle cycle between transactions.
- **Throughput**: with `m_ready` tied high, one transfer per 2 cycles.
- **Abort timing**: an abort occurs in the `TIMEOUT`-th consecutive `m_valid` cycle without `m_ready`.
- **No combinational path**: none from `i_valid`/`d_valid` to `m_*`.

## Test plan
- **Single fetch**: `i_valid`=1, `i_addr`=0x100, memory returns 0x00000013 with 2 wait states → `m_valid` rises 1 cycle after request, `m_addr`=0x100, `m_wstrb`=0. `i_ready` pulses for 1 cycle with `i_rdata`=0x13. `d_ready` stays 0 throughout.
- **Contention, `ARB_MODE`=0**: both valid; `d_addr`=0x2000, `d_wstrb`=0xF, `d_wdata`=0xDEADBEEF; `m_ready` always 1 → D is served first (`m_wdata`=0xDEADBEEF). I is served 2 cycles later with `m_wstrb`=0 and `m_wdata`=0.
- **Round-robin, `ARB_MODE`=1**: both ports request continuously for 8 transfers → grants alternate D,I,D,I…, and `bus_owner` alternates 10/01 with an 00 cycle between each.
- **Timeout, `TIMEOUT`=4**: `m_ready` is never asserted for a D read → in the 4th `m_valid` cycle `d_ready`=1, `d_rdata`=0, `timeout_err`=1 for exactly 1 cycle. `m_valid`=0 the next cycle. A second case with `m_ready` arriving in that same 4th cycle → no error and rdata comes from memory.
- **Reset mid-transfer**: deassert `resetn` while in GRANT_D with `m_valid`=1 → all outputs go 0 asynchronously, before the next edge. After release, an I request is granted normally and the round-robin pointer is back at reset value, so D wins the next contention.

Source files
------------

// File: rtl/vigna_bus_arbiter_if.sv
// Request/response bundle shared by the vigna instruction port, data port and
// the unified memory port. The arbiter connects through the master modport.
interface vigna_bus_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    modport master (
        input  i_valid, i_addr,
        output i_ready, i_rdata,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rdata,
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        output i_valid, i_addr,
        input  i_ready, i_rdata,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rdata,
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/vigna_bus_arbiter.sv
// Shares one memory port between the vigna instruction and data ports,
// with fixed-priority or round-robin arbitration and an optional hang timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transfer in flight; request inputs sampled for a grant
// GRANT_I | instruction fetch owns the memory port
// GRANT_D | data load/store owns the memory port
module vigna_bus_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    vigna_bus_arbiter_if.master bus,
    output logic                timeout_err,
    output logic [1:0]          bus_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    // Wraps to all-ones when TIMEOUT is 0, but abort is gated off in that case.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant_d;
    logic             granted;
    logic             abort;
    logic             done;
    logic             pick_d;

    assign granted = (state != IDLE);
    assign abort   = granted && (TIMEOUT != 0) && !bus.m_ready && (cnt == CNT_LAST);
    assign done    = bus.m_ready || abort;

    // D wins unless I also requests in round-robin mode and D had the last grant.
    assign pick_d = bus.d_valid && (!bus.i_valid || (ARB_MODE == 0) || !last_grant_d);

    assign bus.i_ready = (state == GRANT_I) && done;
    assign bus.d_ready = (state == GRANT_D) && done;
    assign bus.i_rdata = ((state == GRANT_I) && abort) ? '0 : bus.m_rdata;
    assign bus.d_rdata = ((state == GRANT_D) && abort) ? '0 : bus.m_rdata;
    assign timeout_err = abort;
    assign bus_owner   = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant_d <= 1'b0;
            bus.m_valid  <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.m_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state        <= GRANT_D;
                        cnt          <= '0;
                        last_grant_d <= 1'b1;
                        bus.m_valid  <= 1'b1;
                        bus.m_addr   <= bus.d_addr;
                        bus.m_wdata  <= bus.d_wdata;
                        bus.m_wstrb  <= bus.d_wstrb;
                    end else if (bus.i_valid) begin
                        state        <= GRANT_I;
                        cnt          <= '0;
                        last_grant_d <= 1'b0;
                        bus.m_valid  <= 1'b1;
                        bus.m_addr   <= bus.i_addr;
                        bus.m_wdata  <= '0;
                        bus.m_wstrb  <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done) begin
                        state       <= IDLE;
                        bus.m_valid <= 1'b0;
                        bus.m_wdata <= '0;
                        bus.m_wstrb <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Randomized scoreboard bench for vigna_bus_arbiter: one environment in
// fixed-priority mode without timeout, one in round-robin mode with TIMEOUT=4.
module tb_vigna_bus_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  ncyc;
    } rsp_t;

    localparam int NTX = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int MODE = g;
        localparam int TO   = (g == 0) ? 0 : 4;

        logic       resetn;
        logic       timeout_err;
        logic [1:0] bus_owner;
        bit         go, fin, mem_en, mon_en, drv_i_done, drv_d_done;
        req_t       iq[$];
        req_t       dq[$];
        rsp_t       rq[$];

        vigna_bus_arbiter_if bus ();

        vigna_bus_arbiter #(.ARB_MODE(MODE), .TIMEOUT(TO), .CNT_W(16)) dut (
            .clk        (clk),
            .resetn     (resetn),
            .bus        (bus),
            .timeout_err(timeout_err),
            .bus_owner  (bus_owner)
        );

        // Requester: instruction port
        initial begin : drv_i
            req_t r;
            int   gap, t;
            bus.i_valid = 1'b0;
            bus.i_addr  = '0;
            wait (go);
            for (int n = 0; n < NTX; n++) begin
                gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                repeat (gap) begin
                    bus.i_valid = 1'b0;
                    @(posedge clk); #1;
                end
                r.addr  = $urandom;
                r.wdata = '0;
                r.wstrb = '0;
                bus.i_valid = 1'b1;
                bus.i_addr  = r.addr;
                iq.push_back(r);
                t = 0;
                do begin @(negedge clk); t++; end while (!bus.i_ready && t < 200);
                check("i_handshake", bus.i_ready, 1);
                @(posedge clk); #1;
            end
            bus.i_valid = 1'b0;
            drv_i_done  = 1'b1;
        end

        // Requester: data port
        initial begin : drv_d
            req_t r;
            int   gap, t;
            bus.d_valid = 1'b0;
            bus.d_addr  = '0;
            bus.d_wdata = '0;
            bus.d_wstrb = '0;
            wait (go);
            for (int n = 0; n < NTX; n++) begin
                gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                repeat (gap) begin
                    bus.d_valid = 1'b0;
                    @(posedge clk); #1;
                end
                r.addr  = $urandom;
                r.wdata = $urandom;
                r.wstrb = 4'($urandom_range(0, 15));
                bus.d_valid = 1'b1;
                bus.d_addr  = r.addr;
                bus.d_wdata = r.wdata;
                bus.d_wstrb = r.wstrb;
                dq.push_back(r);
                t = 0;
                do begin @(negedge clk); t++; end while (!bus.d_ready && t < 200);
                check("d_handshake", bus.d_ready, 1);
                @(posedge clk); #1;
            end
            bus.d_valid = 1'b0;
            drv_d_done  = 1'b1;
        end

        // Memory: random wait states, occasionally never answers; pushes the expected response
        initial begin : mem
            bit          busy;
            int          k, w, endk, sel;
            logic [31:0] data;
            rsp_t        r;
            busy = 1'b0;
            bus.m_ready = 1'b0;
            bus.m_rdata = '0;
            forever begin
                @(posedge clk); #1;
                if (!mem_en) begin
                    busy = 1'b0;
                    bus.m_ready = 1'b0;
                    bus.m_rdata = $urandom;
                end else begin
                    if (!busy && bus.m_valid) begin
                        busy = 1'b1;
                        k    = 0;
                        data = $urandom;
                        if (TO == 0) begin
                            w = $urandom_range(0, 5);
                        end else begin
                            sel = $urandom_range(0, 5);
                            w   = (sel <= 3) ? sel : ((sel == 4) ? TO - 1 : 50);
                        end
                        r.err   = (TO != 0) && (w >= TO);
                        endk    = r.err ? TO : w + 1;
                        r.rdata = r.err ? 32'h0 : data;
                        r.ncyc  = 8'(endk);
                        rq.push_back(r);
                    end
                    if (busy) begin
                        k++;
                        bus.m_ready = (k == w + 1);
                        bus.m_rdata = bus.m_ready ? data : $urandom;
                        if (k == endk) busy = 1'b0;
                    end else begin
                        bus.m_ready = 1'b0;
                        bus.m_rdata = $urandom;
                    end
                end
            end
        end

        // Monitor: predicts grants from the arbitration rules and pops the scoreboards
        logic       pv_i, pv_d, pv_mv, pv_done, last_d;
        logic [1:0] own;
        int         kk;
        req_t       cur;

        initial begin : mon
            logic exp_mv, done_now;
            rsp_t r;
            forever begin
                @(negedge clk);
                if (!mon_en) begin
                    pv_i = 0; pv_d = 0; pv_mv = 0; pv_done = 0; last_d = 0;
                    own = 2'b00; kk = 0;
                    iq.delete(); dq.delete(); rq.delete();
                end else begin
                    exp_mv = pv_mv ? !pv_done : (pv_i || pv_d);
                    check("m_valid_timing", bus.m_valid, exp_mv);
                    if (bus.m_valid && !pv_mv) begin
                        if (pv_d && pv_i)
                            own = (MODE == 0 || !last_d) ? 2'b10 : 2'b01;
                        else
                            own = pv_d ? 2'b10 : 2'b01;
                        last_d = (own == 2'b10);
                        check("grant_payload_avail", (own == 2'b10) ? (dq.size() != 0) : (iq.size() != 0), 1);
                        if (own == 2'b10 && dq.size() != 0) cur = dq.pop_front();
                        if (own == 2'b01 && iq.size() != 0) cur = iq.pop_front();
                        kk = 1;
                        check("grant_m_addr",  bus.m_addr,  cur.addr);
                        check("grant_m_wdata", bus.m_wdata, cur.wdata);
                        check("grant_m_wstrb", bus.m_wstrb, cur.wstrb);
                    end else if (bus.m_valid) begin
                        kk++;
                        check("hold_m_addr",  bus.m_addr,  cur.addr);
                        check("hold_m_wdata", bus.m_wdata, cur.wdata);
                        check("hold_m_wstrb", bus.m_wstrb, cur.wstrb);
                    end else begin
                        check("idle_m_wdata", bus.m_wdata, 0);
                        check("idle_m_wstrb", bus.m_wstrb, 0);
                    end
                    check("bus_owner", bus_owner, bus.m_valid ? own : 2'b00);
                    done_now = bus.i_ready || bus.d_ready || timeout_err;
                    if (done_now) begin
                        check("rsp_avail", rq.size() != 0, 1);
                        if (rq.size() != 0) begin
                            r = rq.pop_front();
                            check("ready_port", {bus.d_ready, bus.i_ready}, own);
                            if (own == 2'b10) begin
                                check("d_rdata", bus.d_rdata, r.rdata);
                                check("i_rdata_pass", bus.i_rdata, bus.m_rdata);
                            end else begin
                                check("i_rdata", bus.i_rdata, r.rdata);
                                check("d_rdata_pass", bus.d_rdata, bus.m_rdata);
                            end
                            check("timeout_err", timeout_err, r.err);
                            check("xfer_cycles", kk, r.ncyc);
                        end
                    end
                    pv_i = bus.i_valid; pv_d = bus.d_valid;
                    pv_mv = bus.m_valid; pv_done = done_now;
                end
            end
        end

        // Sequencer: reset, random traffic, then reset in the middle of a D transfer
        initial begin : seq
            int t;
            resetn = 1'b0;
            repeat (2) @(posedge clk); #1;
            check("rst_m_valid", bus.m_valid, 0);
            check("rst_m_addr",  bus.m_addr,  0);
            check("rst_owner",   bus_owner,   0);
            check("rst_readies", {bus.d_ready, bus.i_ready}, 0);
            resetn = 1'b1; mem_en = 1'b1; mon_en = 1'b1; go = 1'b1;

            t = 0;
            while (!(drv_i_done && drv_d_done) && t < 20000) begin @(posedge clk); t++; end
            check("drivers_finished", drv_i_done && drv_d_done, 1);
            repeat (4) @(posedge clk);
            @(negedge clk);
            mon_en = 1'b0; mem_en = 1'b0;

            @(posedge clk); #1;
            bus.d_valid = 1'b1; bus.d_addr = 32'h0000_3000;
            bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;
            @(negedge clk);
            check("mid_pre_mv", bus.m_valid, 0);
            @(negedge clk);
            check("mid_grant_mv",    bus.m_valid, 1);
            check("mid_grant_owner", bus_owner,   2'b10);
            check("mid_grant_addr",  bus.m_addr,  32'h0000_3000);
            #2 resetn = 1'b0;
            #1;
            check("async_m_valid", bus.m_valid, 0);
            check("async_m_addr",  bus.m_addr,  0);
            check("async_m_wdata", bus.m_wdata, 0);
            check("async_m_wstrb", bus.m_wstrb, 0);
            check("async_owner",   bus_owner,   0);
            check("async_readies", {bus.d_ready, bus.i_ready}, 0);
            check("async_err",     timeout_err, 0);
            bus.d_valid = 1'b0;
            @(posedge clk); #1;
            check("held_m_valid", bus.m_valid, 0);
            resetn = 1'b1; mem_en = 1'b1; mon_en = 1'b1;

            // Contention right after reset: the round-robin pointer must be back at I, so D wins.
            @(posedge clk); #1;
            cur.addr = 32'h0000_0100;
            bus.i_valid = 1'b1; bus.i_addr = 32'h0000_0100;
            iq.push_back('{addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0});
            bus.d_valid = 1'b1; bus.d_addr = 32'h0000_2000;
            bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
            dq.push_back('{addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF, wstrb: 4'hF});
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.d_ready && t < 100);
            check("post_rst_d_first", bus.d_ready, 1);
            @(posedge clk); #1;
            bus.d_valid = 1'b0;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.i_ready && t < 100);
            check("post_rst_i_served", bus.i_ready, 1);
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            repeat (4) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (!(env[0].fin && env[1].fin) && t < 50000) begin @(posedge clk); t++; end
        check("run_complete", env[0].fin && env[1].fin, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
